instruction_fetch_queue_porc2: RTL

//  Producer side of the fetch->decode interface: issues sequential 16-bit instruction-word reads to

---
 rtl/instruction_fetch_queue_porc2.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_queue_porc2.sv
// Fetch-side producer: issues sequential word reads, buffers in-order responses with their PC tags,
// and presents the queue head to decode. Supports branch redirect (flush + stale drop) and halt.
module instruction_fetch_queue_porc2 #(
  parameter int          ADDRBITWIDTH = 16,
  parameter int          QUEUEDEPTH   = 4,
  parameter int unsigned RESETVECTOR  = 0
) (
  input  logic                    clk,
  input  logic                    async_rst_n,
  input  logic                    clk_en,
  output logic                    FetchReqValid,
  input  logic                    FetchReqReady,
  output logic [ADDRBITWIDTH-1:0] FetchReqAddr,
  input  logic                    FetchRespValid,
  input  logic [15:0]             FetchRespData,
  output logic                    FetchedInstructionValid,
  output logic [15:0]             FetchedInstruction,
  output logic [ADDRBITWIDTH-1:0] FetchedInstructionPC,
  input  logic                    DecodeReady,
  input  logic                    RedirectValid,
  input  logic [ADDRBITWIDTH-1:0] RedirectAddr,
  input  logic                    Halt
);

  localparam int IW = $clog2(QUEUEDEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUEDEPTH);
  localparam logic [ADDRBITWIDTH-1:0] RESET_PC = ADDRBITWIDTH'(RESETVECTOR);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDRBITWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]           out_q, out_d;
  logic [CW-1:0]           drop_q, drop_d;
  logic [CW-1:0]           occ_q, occ_d;
  logic [IW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]           tag_rd_q, tag_rd_d;
  logic [IW-1:0]           tag_wr_q, tag_wr_d;

  logic [15:0]             word_mem [QUEUEDEPTH];
  logic [ADDRBITWIDTH-1:0] pc_mem   [QUEUEDEPTH];
  // Addresses of requests still in flight, consumed in order as responses return.
  logic [ADDRBITWIDTH-1:0] tag_mem  [QUEUEDEPTH];

  logic credit;
  logic req_valid;
  logic req_fire;
  logic resp_fire;
  logic resp_keep;
  logic head_valid;
  logic deq;

  // Stale in-flight requests still hold a slot, so they count against the credit.
  assign credit     = ({1'b0, out_q} + {1'b0, occ_q}) < DEPTH_W;
  assign req_valid  = async_rst_n & clk_en & (state_q == RUN) & ~Halt & ~RedirectValid & credit;
  assign req_fire   = req_valid & FetchReqReady;
  assign resp_fire  = clk_en & FetchRespValid & (out_q != '0);
  assign resp_keep  = resp_fire & (drop_q == '0) & ~RedirectValid;
  assign head_valid = (occ_q != '0);
  assign deq        = clk_en & head_valid & DecodeReady & ~RedirectValid;

  assign FetchReqValid           = req_valid;
  assign FetchReqAddr            = pc_q;
  assign FetchedInstructionValid = head_valid;
  assign FetchedInstruction      = head_valid ? word_mem[rd_ptr_q] : 16'h0000;
  assign FetchedInstructionPC    = head_valid ? pc_mem[rd_ptr_q] : '0;

  always_comb begin
    pc_d     = pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    occ_d    = occ_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    if (clk_en) begin
      out_d    = out_q + CW'(req_fire) - CW'(resp_fire);
      tag_wr_d = tag_wr_q + IW'(req_fire);
      tag_rd_d = tag_rd_q + IW'(resp_fire);
      if (RedirectValid) begin
        // Everything still in flight after this cycle's response belongs to the old path.
        pc_d     = RedirectAddr;
        drop_d   = out_q - CW'(resp_fire);
        occ_d    = '0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end else begin
        if (req_fire) begin
          pc_d = pc_q + ADDRBITWIDTH'(1);
        end
        if (resp_fire && (drop_q != '0)) begin
          drop_d = drop_q - CW'(1);
        end
        occ_d    = occ_q + CW'(resp_keep) - CW'(deq);
        wr_ptr_d = wr_ptr_q + IW'(resp_keep);
        rd_ptr_d = rd_ptr_q + IW'(deq);
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      occ_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      if (clk_en) begin
        if (RedirectValid) begin
          state_q <= RUN;
        end else if (Halt) begin
          state_q <= HALTED;
        end
      end
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      occ_q    <= occ_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Storage only; validity is carried entirely by the pointers and counters above.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (resp_keep) begin
      word_mem[wr_ptr_q] <= FetchRespData;
      pc_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
    end
  end

endmodule
